f_case_sequencer: RTL and testbench

Batch controller for the F-value datapath. It captures one J-element batch of 64-bit H coefficients and AWIDTH-bit x symbols, which may arrive in the same cycle or in different cycles. It then issues the elements one per handshake to the serial double-precision compute stage and collects the per-element results, which may return out of order. When all J results are in, it emits them as one packed F_value word with a single-cycle valid. It replaces free-running FIFO draining with an explicit load/issue/collect schedule.

---
 rtl/f_case_sequencer_if.sv | 33 +++
 rtl/f_case_sequencer.sv | 78 +++++++
 tb/tb_f_case_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/f_case_sequencer_if.sv
// f_case_sequencer_if: batch load, element issue, result return and F_value bundle
interface f_case_sequencer_if #(
  parameter int J = 14,
  parameter int A = 2
);
  localparam int AWIDTH = $clog2(A) + 1;
  localparam int IDXW = $clog2(J);
  logic [J*64-1:0] H;
  logic H_tvalid;
  logic [J*AWIDTH-1:0] x;
  logic x_tvalid;
  logic busy;
  logic [63:0] elem_H;
  logic [AWIDTH-1:0] elem_x;
  logic [IDXW-1:0] elem_idx;
  logic elem_tvalid;
  logic elem_tlast;
  logic elem_tready;
  logic [AWIDTH-1:0] res_data;
  logic [IDXW-1:0] res_idx;
  logic res_tvalid;
  logic [J*AWIDTH-1:0] F_value;
  logic F_value_tvalid;
  logic err;
  modport master (
    output H, H_tvalid, x, x_tvalid, elem_tready, res_data, res_idx, res_tvalid,
    input busy, elem_H, elem_x, elem_idx, elem_tvalid, elem_tlast, F_value, F_value_tvalid, err
  );
  modport slave (
    input H, H_tvalid, x, x_tvalid, elem_tready, res_data, res_idx, res_tvalid,
    output busy, elem_H, elem_x, elem_idx, elem_tvalid, elem_tlast, F_value, F_value_tvalid, err
  );
endinterface

// File: rtl/f_case_sequencer.sv
// f_case_sequencer: loads an H/x batch, issues elements serially, collects out-of-order results into F_value
module f_case_sequencer #(
  parameter int J = 14,
  parameter int A = 2
) (
  input logic clk,
  input logic rst,
  f_case_sequencer_if.slave bus
);
  localparam int AWIDTH = $clog2(A) + 1;
  localparam int IDXW = $clog2(J);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, COLLECT, DONE} state_t;
  state_t state, state_n;
  logic have_h, have_x, hn, xn;
  logic [J*64-1:0] hbuf;
  logic [J*AWIDTH-1:0] xbuf, shadow, shadow_n;
  logic [IDXW-1:0] idx;
  logic [J-1:0] rmask, rmask_n;
  logic loading, collecting, res_in, res_ok, hs, last_hs, all_in, err_n;
  assign loading = state == IDLE || state == LOAD;
  assign collecting = state == ISSUE || state == COLLECT;
  assign hn = have_h || bus.H_tvalid;
  assign xn = have_x || bus.x_tvalid;
  assign res_in = int'(bus.res_idx) < J;
  assign res_ok = bus.res_tvalid && res_in;
  assign hs = state == ISSUE && bus.elem_tready;
  assign last_hs = hs && idx == IDXW'(J - 1);
  // the current cycle's result counts toward completion
  assign rmask_n = rmask | ((collecting && res_ok) ? (J'(1) << bus.res_idx) : '0);
  assign all_in = &rmask_n;
  assign err_n = (!loading && (bus.H_tvalid || bus.x_tvalid)) || (bus.res_tvalid && !res_in) ||
                 (collecting && res_ok && rmask[bus.res_idx]) || (loading && bus.res_tvalid);
  always_comb begin
    shadow_n = shadow;
    if (collecting && res_ok) shadow_n[bus.res_idx*AWIDTH +: AWIDTH] = bus.res_data;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = loading ? (hn && xn ? ISSUE : (hn || xn) ? LOAD : IDLE)
            : state == ISSUE ? (last_hs ? (all_in ? DONE : COLLECT) : ISSUE)
            : state == COLLECT ? (all_in ? DONE : COLLECT)
            : IDLE;
  end
  always_comb begin
    bus.busy = !loading;
    bus.elem_tvalid = state == ISSUE;
    bus.elem_H = state == ISSUE ? hbuf[idx*64 +: 64] : '0;
    bus.elem_x = state == ISSUE ? xbuf[idx*AWIDTH +: AWIDTH] : '0;
    bus.elem_idx = state == ISSUE ? idx : '0;
    bus.elem_tlast = state == ISSUE && idx == IDXW'(J - 1);
    bus.F_value_tvalid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_h <= 1'b0;
      have_x <= 1'b0;
      hbuf <= '0;
      xbuf <= '0;
      idx <= '0;
      rmask <= '0;
      shadow <= '0;
      bus.F_value <= '0;
      bus.err <= 1'b0;
    end else begin
      if (loading && bus.H_tvalid) hbuf <= bus.H;
      if (loading && bus.x_tvalid) xbuf <= bus.x;
      have_h <= state == DONE ? 1'b0 : loading ? hn : have_h;
      have_x <= state == DONE ? 1'b0 : loading ? xn : have_x;
      idx <= loading ? '0 : hs ? (last_hs ? '0 : idx + 1'b1) : idx;
      rmask <= loading ? '0 : rmask_n;
      shadow <= shadow_n;
      if (collecting && state_n == DONE) bus.F_value <= shadow_n;
      bus.err <= bus.err || err_n;
    end
  end
endmodule

// File: tb/tb_f_case_sequencer.sv
// tb_f_case_sequencer: randomized batches against a slot/mask reference model
module tb_f_case_sequencer;
  localparam int J = 14;
  localparam int AW = 2;
  typedef struct {int due; int idx; int dat;} res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  f_case_sequencer_if #(.J(J), .A(2)) bus ();
  f_case_sequencer #(.J(J), .A(2)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_run = 0;
  int n_fail = 0;
  logic [63:0] hm [J];
  logic [AW-1:0] xm [J];
  logic [AW-1:0] slot [J];
  logic [J-1:0] got;
  logic err_exp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [J*AW-1:0] pack_slots();
    logic [J*AW-1:0] p;
    for (int j = 0; j < J; j++) p[j*AW +: AW] = slot[j];
    return p;
  endfunction

  // mode 0: same-cycle load, ready high, result j = j mod 4 three cycles after issue
  // mode 1: split arrival with H overwrite, random ready and result delays
  // mode 2: ready 1,0,0,1 pattern, results 13..0 with index 5 twice
  // mode 3: H_tvalid while busy and an out-of-range result index
  // mode 4: reset in COLLECT after 7 results
  task automatic run_batch(input int mode);
    logic [J*64-1:0] hv;
    logic [J*AW-1:0] xv;
    res_t q[$];
    res_t r;
    int issued, cyc, lastdue, due, d;
    bit pulse_exp, seen, listed, rdy;
    issued = 0; cyc = 0; lastdue = -1; pulse_exp = 0; seen = 0; listed = 0;
    got = '0;
    for (int j = 0; j < J; j++) begin
      hm[j] = {$urandom, $urandom};
      xm[j] = AW'($urandom);
      hv[j*64 +: 64] = hm[j];
      xv[j*AW +: AW] = xm[j];
    end
    if (mode == 1) begin
      for (int c = 0; c < 6; c++) begin
        bus.H = (c == 0) ? ~hv : hv;
        bus.H_tvalid = (c == 0 || c == 3);
        bus.x = xv;
        bus.x_tvalid = (c == 5);
        @(posedge clk); @(negedge clk);
        bus.H_tvalid = 1'b0;
        bus.x_tvalid = 1'b0;
        if (c < 5) begin
          chk("load_busy", 64'(bus.busy), 64'(0));
          chk("load_tvalid", 64'(bus.elem_tvalid), 64'(0));
        end
      end
    end else begin
      bus.H = hv; bus.x = xv; bus.H_tvalid = 1'b1; bus.x_tvalid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.H_tvalid = 1'b0; bus.x_tvalid = 1'b0;
    end
    while (cyc < 300) begin
      chk("f_tvalid", 64'(bus.F_value_tvalid), 64'(pulse_exp));
      chk("err", 64'(bus.err), 64'(err_exp));
      if (pulse_exp) begin
        chk("f_value", 64'(bus.F_value), 64'(pack_slots()));
        seen = 1;
        break;
      end
      if (mode == 4 && listed && q.size() == 0) break;
      chk("busy", 64'(bus.busy), 64'(1));
      chk("e_tvalid", 64'(bus.elem_tvalid), 64'(issued < J));
      if (issued < J) begin
        chk("e_idx", 64'(bus.elem_idx), 64'(issued));
        chk("e_H", bus.elem_H, hm[issued]);
        chk("e_x", 64'(bus.elem_x), 64'(xm[issued]));
        chk("e_tlast", 64'(bus.elem_tlast), 64'(issued == J - 1));
      end
      rdy = (mode == 0 || mode == 4) ? 1'b1 : mode == 2 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom);
      bus.elem_tready = rdy;
      if (rdy && issued < J) begin
        if (mode <= 1 || mode == 3) begin
          d = mode == 1 ? int'($urandom_range(0, 4)) : 3;
          due = cyc + d;
          if (due <= lastdue) due = lastdue + 1;
          lastdue = due;
          q.push_back('{due, issued, mode == 0 ? issued % 4 : int'($urandom_range(0, 3))});
        end
        issued++;
      end
      if (issued == J && !listed && (mode == 2 || mode == 4)) begin
        listed = 1;
        due = cyc + 1;
        if (mode == 2) begin
          for (int j = J - 1; j >= 0; j--) begin
            d = int'($urandom_range(0, 3));
            q.push_back('{due, j, d});
            due++;
            if (j == 5) begin
              q.push_back('{due, j, d ^ 1});
              due++;
            end
          end
        end else begin
          for (int j = 0; j < 7; j++) begin
            q.push_back('{due, j, int'($urandom_range(0, 3))});
            due++;
          end
        end
      end
      bus.res_tvalid = 1'b0; bus.res_idx = '0; bus.res_data = '0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        bus.res_tvalid = 1'b1;
        bus.res_idx = 4'(r.idx);
        bus.res_data = AW'(r.dat);
        if (got[r.idx]) err_exp = 1'b1;
        slot[r.idx] = AW'(r.dat);
        got[r.idx] = 1'b1;
      end else if (mode == 3 && cyc == 0) begin
        bus.res_tvalid = 1'b1;
        bus.res_idx = 4'(J);
        bus.res_data = 2'd3;
        err_exp = 1'b1;
      end
      if (mode == 3 && cyc == 2) begin
        bus.H = ~hv;
        bus.H_tvalid = 1'b1;
        err_exp = 1'b1;
      end
      pulse_exp = issued == J && &got;
      @(posedge clk); @(negedge clk);
      bus.elem_tready = 1'b0; bus.res_tvalid = 1'b0; bus.H_tvalid = 1'b0;
      cyc++;
    end
    if (mode == 4) begin
      rst = 1'b1;
      #1;
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_tvalid", 64'(bus.elem_tvalid), 64'(0));
      chk("rst_fvalue", 64'(bus.F_value), 64'(0));
      chk("rst_fvalid", 64'(bus.F_value_tvalid), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      err_exp = 1'b0;
      @(negedge clk);
      chk("post_rst_fvalid", 64'(bus.F_value_tvalid), 64'(0));
      chk("post_rst_busy", 64'(bus.busy), 64'(0));
    end else begin
      chk("done_seen", 64'(seen), 64'(1));
      @(posedge clk); @(negedge clk);
      chk("after_busy", 64'(bus.busy), 64'(0));
      chk("after_fvalid", 64'(bus.F_value_tvalid), 64'(0));
      chk("f_hold", 64'(bus.F_value), 64'(pack_slots()));
    end
  endtask

  initial begin
    bus.H = '0; bus.H_tvalid = 1'b0; bus.x = '0; bus.x_tvalid = 1'b0;
    bus.elem_tready = 1'b0; bus.res_data = '0; bus.res_idx = '0; bus.res_tvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_tvalid", 64'(bus.elem_tvalid), 64'(0));
    chk("reset_tlast", 64'(bus.elem_tlast), 64'(0));
    chk("reset_eH", bus.elem_H, 64'(0));
    chk("reset_ex", 64'(bus.elem_x), 64'(0));
    chk("reset_eidx", 64'(bus.elem_idx), 64'(0));
    chk("reset_fvalue", 64'(bus.F_value), 64'(0));
    chk("reset_fvalid", 64'(bus.F_value_tvalid), 64'(0));
    chk("reset_err", 64'(bus.err), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    run_batch(0);
    run_batch(1);
    run_batch(2);
    rst = 1'b1; err_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("err_cleared", 64'(bus.err), 64'(0));
    for (int i = 0; i < 3; i++) run_batch(1);
    run_batch(3);
    run_batch(4);
    run_batch(0);
    run_batch(1);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
